// File: rtl/rc5_host_ctrl_if.sv
// Byte link between the host controller and a UART/FIFO style byte source/sink.
// Pure wiring, no latency.
// Rx side is valid/ready into the controller; Tx side is valid/ready out of it.
interface rc5_host_ctrl_if;
    logic [7:0] iRx_data;
    logic       iRx_valid;
    logic       oRx_ready;
    logic [7:0] oTx_data;
    logic       oTx_valid;
    logic       iTx_ready;

    // Link side: supplies command bytes, consumes response bytes
    modport master (
        output iRx_data, iRx_valid, iTx_ready,
        input  oRx_ready, oTx_data, oTx_valid
    );

    // Controller side
    modport slave (
        input  iRx_data, iRx_valid, iTx_ready,
        output oRx_ready, oTx_data, oTx_valid
    );
endinterface

// File: rtl/rc5_host_ctrl.sv
// Host-side command parser driving the RC5 core: key load, block load, run, result stream-out.
// Latency: last payload byte -> start 1 cycle; done -> first response byte 1 cycle.
// Backpressure: oRx_ready low outside IDLE/KEY/LOAD; response bytes held until iTx_ready.
module rc5_host_ctrl #(
    parameter  int W        = 32,
    parameter  int B        = 16,
    parameter  int TIMEOUT  = 1024,
    localparam int U        = W / 8,
    localparam int B_LENGTH = $clog2(B)
) (
    input  logic                clk,
    input  logic                rst,
    rc5_host_ctrl_if.slave      link,
    output logic [7:0]          oKey_sub_i,
    output logic [B_LENGTH-1:0] oKey_address,
    output logic                oWen,
    output logic [W-1:0]        oA,
    output logic [W-1:0]        oB,
    output logic                oStartCipher,
    output logic                oStartDecipher,
    input  logic [W-1:0]        iA_cipher,
    input  logic [W-1:0]        iB_cipher,
    input  logic [W-1:0]        iA_decipher,
    input  logic [W-1:0]        iB_decipher,
    input  logic                iDoneCipher,
    input  logic                iDoneDecipher,
    output logic                oKeyValid,
    output logic                oBusy
);
    localparam int CMAX = (B > 2 * U) ? B : 2 * U;
    localparam int CW   = $clog2(CMAX);
    localparam int TW   = $clog2(TIMEOUT + 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_KEY  = 3'd1;
    localparam logic [2:0] S_LOAD = 3'd2;
    localparam logic [2:0] S_RUN  = 3'd3;
    localparam logic [2:0] S_SEND = 3'd4;
    localparam logic [2:0] S_ERR  = 3'd5;

    logic [2:0]          state_q, state_d;
    logic                op_dec_q, op_dec_d;     // 1 = decrypt
    logic [CW-1:0]       cnt_q, cnt_d;           // byte index within key/payload/response
    logic [W-1:0]        a_q, a_d, b_q, b_d;
    logic                key_valid_q, key_valid_d;
    logic                wen_q, wen_d;
    logic [B_LENGTH-1:0] kaddr_q, kaddr_d;
    logic [7:0]          kdata_q, kdata_d;
    logic                st_c_q, st_c_d, st_d_q, st_d_d;
    logic [TW-1:0]       tmo_q, tmo_d;           // cycles spent in RUN
    logic [2*W-1:0]      res_q, res_d;           // {B,A} result, shifted out LSB first

    logic rx_rdy, rx_fire, tx_vld, tx_fire, done_m;

    assign rx_rdy  = (state_q == S_IDLE) || (state_q == S_KEY) || (state_q == S_LOAD);
    assign rx_fire = link.iRx_valid && rx_rdy;
    assign tx_vld  = (state_q == S_SEND) || (state_q == S_ERR);
    assign tx_fire = tx_vld && link.iTx_ready;
    assign done_m  = op_dec_q ? iDoneDecipher : iDoneCipher;

    // Command sequencing: next-state and datapath updates
    always_comb begin
        state_d     = state_q;
        op_dec_d    = op_dec_q;
        cnt_d       = cnt_q;
        a_d         = a_q;
        b_d         = b_q;
        key_valid_d = key_valid_q;
        wen_d       = 1'b0;
        kaddr_d     = kaddr_q;
        kdata_d     = kdata_q;
        st_c_d      = st_c_q;
        st_d_d      = st_d_q;
        tmo_d       = tmo_q;
        res_d       = res_q;
        case (state_q)
            S_IDLE: begin
                if (rx_fire) begin
                    cnt_d = '0;
                    case (link.iRx_data)
                        8'h4B: state_d = S_KEY;
                        8'h45: begin state_d = S_LOAD; op_dec_d = 1'b0; end
                        8'h44: begin state_d = S_LOAD; op_dec_d = 1'b1; end
                        default: state_d = S_ERR;
                    endcase
                end
            end
            S_KEY: begin
                if (rx_fire) begin
                    wen_d   = 1'b1;
                    kaddr_d = B_LENGTH'(cnt_q);
                    kdata_d = link.iRx_data;
                    if (cnt_q == CW'(B - 1)) begin
                        key_valid_d = 1'b1;
                        cnt_d       = '0;
                        state_d     = S_IDLE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            S_LOAD: begin
                if (rx_fire) begin
                    // Shifting in from the top leaves the first byte in the LSB lane
                    if (cnt_q < CW'(U)) a_d = {link.iRx_data, a_q[W-1:8]};
                    else                b_d = {link.iRx_data, b_q[W-1:8]};
                    if (cnt_q == CW'(2 * U - 1)) begin
                        cnt_d = '0;
                        tmo_d = '0;
                        if (key_valid_q) begin
                            state_d = S_RUN;
                            st_c_d  = !op_dec_q;
                            st_d_d  = op_dec_q;
                        end else begin
                            state_d = S_ERR;
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            S_RUN: begin
                // tmo_q==0 is the first RUN cycle: a done left over from a previous op is ignored
                if (done_m && tmo_q != '0) begin
                    res_d   = op_dec_q ? {iB_decipher, iA_decipher} : {iB_cipher, iA_cipher};
                    st_c_d  = 1'b0;
                    st_d_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = S_SEND;
                end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                    st_c_d  = 1'b0;
                    st_d_d  = 1'b0;
                    state_d = S_ERR;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            S_SEND: begin
                if (tx_fire) begin
                    res_d = res_q >> 8;
                    if (cnt_q == CW'(2 * U - 1)) begin
                        cnt_d   = '0;
                        state_d = S_IDLE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            S_ERR: begin
                if (tx_fire) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers, cleared immediately on reset to abort any operation
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            op_dec_q    <= 1'b0;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            key_valid_q <= 1'b0;
            wen_q       <= 1'b0;
            kaddr_q     <= '0;
            kdata_q     <= '0;
            st_c_q      <= 1'b0;
            st_d_q      <= 1'b0;
            tmo_q       <= '0;
            res_q       <= '0;
        end else begin
            state_q     <= state_d;
            op_dec_q    <= op_dec_d;
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            key_valid_q <= key_valid_d;
            wen_q       <= wen_d;
            kaddr_q     <= kaddr_d;
            kdata_q     <= kdata_d;
            st_c_q      <= st_c_d;
            st_d_q      <= st_d_d;
            tmo_q       <= tmo_d;
            res_q       <= res_d;
        end
    end

    assign link.oRx_ready = rx_rdy;
    assign link.oTx_valid = tx_vld;
    assign link.oTx_data  = (state_q == S_SEND) ? res_q[7:0] :
                            (state_q == S_ERR)  ? 8'hEE : 8'h00;
    assign oKey_sub_i     = kdata_q;
    assign oKey_address   = kaddr_q;
    assign oWen           = wen_q;
    assign oA             = a_q;
    assign oB             = b_q;
    assign oStartCipher   = st_c_q;
    assign oStartDecipher = st_d_q;
    assign oKeyValid      = key_valid_q;
    assign oBusy          = (state_q != S_IDLE);
endmodule

// File: tb/tb_rc5_host_ctrl.sv
// Bench for rc5_host_ctrl: random commands, an RC5 core stand-in, scoreboarded byte/write/start monitors.
module tb_rc5_host_ctrl;
    localparam int TMO = 100;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rc5_host_ctrl_if link();
    logic [7:0]  oKey_sub_i;
    logic [3:0]  oKey_address;
    logic        oWen, oStartCipher, oStartDecipher, oKeyValid, oBusy;
    logic [31:0] oA, oB, iA_cipher, iB_cipher, iA_decipher, iB_decipher;
    logic        iDoneCipher, iDoneDecipher;

    rc5_host_ctrl #(.W(32), .B(16), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .link(link),
        .oKey_sub_i(oKey_sub_i), .oKey_address(oKey_address), .oWen(oWen),
        .oA(oA), .oB(oB), .oStartCipher(oStartCipher), .oStartDecipher(oStartDecipher),
        .iA_cipher(iA_cipher), .iB_cipher(iB_cipher),
        .iA_decipher(iA_decipher), .iB_decipher(iB_decipher),
        .iDoneCipher(iDoneCipher), .iDoneDecipher(iDoneDecipher),
        .oKeyValid(oKeyValid), .oBusy(oBusy)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- RC5-32/12/16 reference ----------------
    function automatic logic [31:0] rotl(input logic [31:0] x, input logic [31:0] n);
        int s;
        s = int'(n[4:0]);
        if (s == 0) return x;
        return (x << s) | (x >> (32 - s));
    endfunction

    function automatic logic [31:0] rotr(input logic [31:0] x, input logic [31:0] n);
        return rotl(x, 32'd32 - {27'd0, n[4:0]});
    endfunction

    // key byte i at k[8i+:8]; returns {B,A}
    function automatic logic [63:0] rc5(input logic [127:0] k, input logic [31:0] ai,
                                        input logic [31:0] bi, input logic dec);
        logic [31:0] s [26];
        logic [31:0] l [4];
        logic [31:0] a, b;
        int i, j;
        for (int n = 0; n < 4; n++) l[n] = k[32*n +: 32];
        s[0] = 32'hB7E15163;
        for (int n = 1; n < 26; n++) s[n] = s[n-1] + 32'h9E3779B9;
        a = 0; b = 0; i = 0; j = 0;
        for (int n = 0; n < 78; n++) begin
            s[i] = rotl(s[i] + a + b, 3);
            a = s[i];
            l[j] = rotl(l[j] + a + b, a + b);
            b = l[j];
            i = (i + 1) % 26;
            j = (j + 1) % 4;
        end
        a = ai; b = bi;
        if (!dec) begin
            a = a + s[0]; b = b + s[1];
            for (int r = 1; r <= 12; r++) begin
                a = rotl(a ^ b, b) + s[2*r];
                b = rotl(b ^ a, a) + s[2*r+1];
            end
        end else begin
            for (int r = 12; r >= 1; r--) begin
                b = rotr(b - s[2*r+1], a) ^ a;
                a = rotr(a - s[2*r], b) ^ b;
            end
            b = b - s[1]; a = a - s[0];
        end
        return {b, a};
    endfunction

    // ---------------- RC5 core stand-in ----------------
    logic [127:0] kram;
    int lat, tgt;
    bit hang = 0;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            iDoneCipher <= 0; iDoneDecipher <= 0; lat <= 0; tgt <= 2; kram <= '0;
            iA_cipher <= 0; iB_cipher <= 0; iA_decipher <= 0; iB_decipher <= 0;
        end else begin
            if (oWen) kram[oKey_address*8 +: 8] <= oKey_sub_i;
            if (oStartCipher || oStartDecipher) begin
                lat <= lat + 1;
                // done from the previous op stays up into the first RUN cycle
                if (lat == 0) begin iDoneCipher <= 0; iDoneDecipher <= 0; end
                if (oStartCipher) begin
                    iDoneDecipher <= 1'($urandom_range(0, 1));
                    {iB_decipher, iA_decipher} <= {$urandom, $urandom};
                end else begin
                    iDoneCipher <= 1'($urandom_range(0, 1));
                    {iB_cipher, iA_cipher} <= {$urandom, $urandom};
                end
                if (!hang && lat == tgt) begin
                    if (oStartCipher) begin
                        {iB_cipher, iA_cipher} <= rc5(kram, oA, oB, 1'b0);
                        iDoneCipher <= 1;
                    end else begin
                        {iB_decipher, iA_decipher} <= rc5(kram, oA, oB, 1'b1);
                        iDoneDecipher <= 1;
                    end
                end
            end else begin
                lat <= 0;
                tgt <= $urandom_range(1, 6);
            end
        end
    end

    // ---------------- scoreboard ----------------
    logic [7:0]  exp_tx [$];
    logic [11:0] exp_wr [$];
    int          exp_st [$];      // 1 = cipher, 2 = decipher
    logic [127:0] key_m;
    bit          key_valid_m = 0;
    bit          stall_req = 0;
    int          stall_cnt = 0;
    bit          stalled_prev = 0;
    logic [7:0]  prev_dat;
    logic [1:0]  prev_st = 0;

    // Drive iTx_ready, then check all DUT outputs just after the falling edge
    always @(negedge clk) begin
        if (stall_req && link.oTx_valid) begin stall_cnt = 5; stall_req = 0; end
        if (stall_cnt > 0) begin link.iTx_ready = 0; stall_cnt--; end
        else link.iTx_ready = ($urandom_range(0, 3) != 0);
        #1;
        if (!rst) begin
            stalled_prev = 0; prev_st = 0;
        end else begin
            if (stalled_prev)
                chk("tx_hold", {55'd0, link.oTx_valid, link.oTx_data}, {55'd0, 1'b1, prev_dat});
            if (link.oTx_valid && link.iTx_ready) begin
                if (exp_tx.size() == 0) chk("tx_unexpected", {56'd0, link.oTx_data}, 64'h1_0000);
                else chk("tx_byte", {56'd0, link.oTx_data}, {56'd0, exp_tx.pop_front()});
            end
            stalled_prev = link.oTx_valid && !link.iTx_ready;
            prev_dat = link.oTx_data;
            if (oWen) begin
                if (exp_wr.size() == 0) chk("key_wr_unexpected", {52'd0, oKey_address, oKey_sub_i}, 64'h1_0000);
                else chk("key_wr", {52'd0, oKey_address, oKey_sub_i}, {52'd0, exp_wr.pop_front()});
            end
            if (oStartCipher && oStartDecipher) chk("start_both", 64'd3, 64'd0);
            if ({oStartCipher, oStartDecipher} != 2'b00 && prev_st == 2'b00) begin
                if (exp_st.size() == 0) chk("start_unexpected", {62'd0, oStartDecipher, oStartCipher}, 64'd0);
                else chk("start_kind", {62'd0, oStartDecipher, oStartCipher}, 64'(exp_st.pop_front()));
            end
            prev_st = {oStartCipher, oStartDecipher};
        end
    end

    // ---------------- stimulus ----------------
    task automatic send_byte(input logic [7:0] b);
        int n;
        repeat ($urandom_range(0, 1)) @(negedge clk);
        link.iRx_data = b; link.iRx_valid = 1; n = 0;
        while (!link.oRx_ready && n < 5000) begin @(negedge clk); n++; end
        if (n >= 5000) chk("rx_accept_timeout", 64'd0, 64'd1);
        @(negedge clk);
        link.iRx_valid = 0;
    endtask

    task automatic do_key(input logic [127:0] k);
        send_byte(8'h4B);
        for (int i = 0; i < 16; i++) begin
            exp_wr.push_back({4'(i), k[8*i +: 8]});
            send_byte(k[8*i +: 8]);
        end
        key_m = k; key_valid_m = 1;
    endtask

    task automatic do_op(input logic dec, input logic [63:0] pl, input bit use_model);
        logic [63:0] r;
        if (!key_valid_m) exp_tx.push_back(8'hEE);
        else begin
            exp_st.push_back(dec ? 2 : 1);
            if (use_model) begin
                r = rc5(key_m, pl[31:0], pl[63:32], dec);
                for (int m = 0; m < 8; m++) exp_tx.push_back(r[8*m +: 8]);
            end
        end
        send_byte(dec ? 8'h44 : 8'h45);
        for (int m = 0; m < 8; m++) send_byte(pl[8*m +: 8]);
    endtask

    task automatic bad_op();
        logic [7:0] b;
        b = 8'($urandom);
        while (b == 8'h4B || b == 8'h45 || b == 8'h44) b = 8'($urandom);
        exp_tx.push_back(8'hEE);
        send_byte(b);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        repeat (2) @(negedge clk);
        while ((exp_tx.size() != 0 || oBusy) && n < 20000) begin @(negedge clk); n++; end
        if (n >= 20000) chk("idle_timeout", 64'(exp_tx.size()), 64'd0);
        @(negedge clk);
        chk("key_valid", {63'd0, oKeyValid}, {63'd0, key_valid_m});
        chk("writes_drained", 64'(exp_wr.size()), 64'd0);
    endtask

    initial begin
        int hi, n;
        logic [63:0] lit;
        link.iRx_data = 0; link.iRx_valid = 0; link.iTx_ready = 0;
        rst = 0;
        #1;
        chk("rst_outputs", {58'd0, oStartCipher, oStartDecipher, oWen, link.oTx_valid, oBusy, oKeyValid}, 64'd0);
        repeat (3) @(negedge clk);
        rst = 1;

        // no key yet: op is consumed then errors; unknown opcode errors
        do_op(1'b0, {$urandom, $urandom}, 1'b1);
        wait_idle();
        exp_tx.push_back(8'hEE);
        send_byte(8'h7F);
        wait_idle();

        // all-zero key, then the known vector both ways (with a 5-cycle tx stall)
        do_key(128'd0);
        wait_idle();
        stall_req = 1;
        lit = 64'h6D8F4B15_EEDBA521;
        for (int m = 0; m < 8; m++) exp_tx.push_back(lit[8*m +: 8]);
        do_op(1'b0, 64'd0, 1'b0);
        wait_idle();
        for (int m = 0; m < 8; m++) exp_tx.push_back(8'h00);
        do_op(1'b1, lit, 1'b0);
        wait_idle();

        // random keys and commands
        for (int k = 0; k < 4; k++) begin
            do_key({$urandom, $urandom, $urandom, $urandom});
            for (int j = 0; j < 6; j++) begin
                if ($urandom_range(0, 7) == 0) bad_op();
                else do_op(1'($urandom_range(0, 1)), {$urandom, $urandom}, 1'b1);
                wait_idle();
            end
        end

        // core never finishes: start held exactly TMO cycles then 0xEE
        hang = 1;
        exp_tx.push_back(8'hEE);
        do_op(1'b0, {$urandom, $urandom}, 1'b0);
        hi = 0; n = 0;
        while (oStartCipher && n < 2000) begin hi++; @(negedge clk); n++; end
        chk("timeout_len", 64'(hi), 64'(TMO));
        wait_idle();

        // reset in the middle of RUN
        exp_st.push_back(2);
        send_byte(8'h44);
        for (int m = 0; m < 8; m++) send_byte(8'($urandom));
        repeat (3) @(negedge clk);
        chk("run_before_rst", {63'd0, oStartDecipher}, 64'd1);
        rst = 0;
        #1;
        chk("rst_mid_run", {oA, 26'd0, oStartCipher, oStartDecipher, oWen, link.oTx_valid, oBusy, oKeyValid}, 64'd0);
        @(negedge clk);
        rst = 1; hang = 0; key_valid_m = 0;
        do_op(1'b0, {$urandom, $urandom}, 1'b1);
        wait_idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
